// File: rtl/quad_decoder.sv
// Quadrature A/B decoder: synchronizes and glitch-filters both channels, decodes
// 4x Gray transitions and drives an up/down/load position counter.
module quad_decoder #(
    parameter int BITS        = 8,
    parameter int SYNC_STAGES = 2,
    parameter int FILT_CYCLES = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            enable,
    input  logic            a_in,
    input  logic            b_in,
    input  logic            load,
    input  logic [BITS-1:0] D,
    output logic [BITS-1:0] Q,
    output logic            step,
    output logic            dir,
    output logic            err
);

    localparam int FW = (FILT_CYCLES > 1) ? $clog2(FILT_CYCLES) : 1;
    // Sync fill, then filtered and prev each need one more edge to settle on the resting state.
    localparam int STARTUP = SYNC_STAGES + 2;
    localparam int SW      = $clog2(STARTUP + 1);

    logic [SYNC_STAGES-1:0] a_sync, b_sync;
    logic [1:0]             synced, filtered, prev;
    logic [1:0][FW-1:0]     filt_cnt;
    logic [SW-1:0]          startup_cnt;
    logic                   starting;
    logic [1:0]             delta;
    logic                   move_up, move_dn, illegal;

    // Position of a {A,B} pair along the up sequence 00->10->11->01.
    function automatic logic [1:0] gray_idx(input logic [1:0] s);
        return {s[0], s[1] ^ s[0]};
    endfunction

    assign synced   = {a_sync[SYNC_STAGES-1], b_sync[SYNC_STAGES-1]};
    assign starting = (startup_cnt != '0);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            a_sync <= '0;
            b_sync <= '0;
        end else begin
            a_sync <= {a_sync[SYNC_STAGES-2:0], a_in};
            b_sync <= {b_sync[SYNC_STAGES-2:0], b_in};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            filtered <= '0;
            filt_cnt <= '0;
        end else begin
            for (int ch = 0; ch < 2; ch++) begin
                if (starting) begin
                    filtered[ch] <= synced[ch];
                    filt_cnt[ch] <= '0;
                end else if (synced[ch] == filtered[ch]) begin
                    filt_cnt[ch] <= '0;
                end else if (filt_cnt[ch] == FW'(FILT_CYCLES - 1)) begin
                    filtered[ch] <= synced[ch];
                    filt_cnt[ch] <= '0;
                end else begin
                    filt_cnt[ch] <= filt_cnt[ch] + FW'(1);
                end
            end
        end
    end

    always_comb begin
        delta   = gray_idx(filtered) - gray_idx(prev);
        move_up = (delta == 2'd1);
        move_dn = (delta == 2'd3);
        illegal = (delta == 2'd2);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            Q           <= '0;
            step        <= 1'b0;
            dir         <= 1'b0;
            err         <= 1'b0;
            prev        <= '0;
            startup_cnt <= SW'(STARTUP);
        end else begin
            prev <= filtered;
            step <= 1'b0;
            err  <= 1'b0;
            if (starting) begin
                startup_cnt <= startup_cnt - SW'(1);
            end else begin
                err <= illegal;
                if (move_up || move_dn)
                    dir <= move_up;
            end
            if (load) begin
                Q <= D;
            end else if (!starting && enable && (move_up || move_dn)) begin
                Q    <= move_up ? Q + BITS'(1) : Q - BITS'(1);
                step <= 1'b1;
            end
        end
    end

endmodule
